// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU and buffered LSU results into the register-file write port and keeps the pending-write scoreboard.
// Optional macro WB_BYPASS_EN adds write-port bypass outputs for the issue stage.
module wb_arbiter #(
    parameter int XLEN      = 32,
    parameter int LSU_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            rf_we,
    output logic [4:0]      rf_wa,
    output logic [XLEN-1:0] rf_wd,
    input  logic [4:0]      query_ra1,
    input  logic [4:0]      query_ra2,
    output logic            busy1,
    output logic            busy2
`ifdef WB_BYPASS_EN
    ,
    output logic            byp1_valid,
    output logic            byp2_valid,
    output logic [XLEN-1:0] byp1_data,
    output logic [XLEN-1:0] byp2_data
`endif
);

    localparam int PTR_W = $clog2(LSU_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_ALU  = 2'd1;
    localparam logic [1:0] SRC_FIFO = 2'd2;

    logic [4:0]      fifo_rd   [LSU_DEPTH];
    logic [XLEN-1:0] fifo_data [LSU_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    logic [1:0]       sel;
    logic [4:0]       win_rd;
    logic [XLEN-1:0]  win_data;

    logic [31:0]      scoreboard;
    logic [31:0]      scoreboard_next;

    assign full  = (count == CNT_W'(LSU_DEPTH));
    assign empty = (count == '0);

    assign alu_ready = !reset && !full;
    assign lsu_ready = !reset && !full;
    assign push      = lsu_valid && lsu_ready;
    assign pop       = (sel == SRC_FIFO);

    // A full FIFO takes the port ahead of the ALU so loads can never starve.
    always_comb begin
        sel      = SRC_NONE;
        win_rd   = 5'd0;
        win_data = '0;
        if (!reset) begin
            if (full) begin
                sel = SRC_FIFO;
            end else if (alu_valid) begin
                sel = SRC_ALU;
            end else if (!empty) begin
                sel = SRC_FIFO;
            end
        end
        if (sel == SRC_ALU) begin
            win_rd   = alu_rd;
            win_data = alu_data;
        end else if (sel == SRC_FIFO) begin
            win_rd   = fifo_rd[head];
            win_data = fifo_data[head];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[tail]   <= lsu_rd;
            fifo_data[tail] <= lsu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Writes to x0 are consumed like any other result but never enable the port.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we <= 1'b0;
            rf_wa <= 5'd0;
            rf_wd <= '0;
        end else if (sel != SRC_NONE) begin
            rf_we <= (win_rd != 5'd0);
            rf_wa <= win_rd;
            rf_wd <= win_data;
        end else begin
            rf_we <= 1'b0;
        end
    end

    // The set is applied after the clear so a re-issue to the register being written stays pending.
    always_comb begin
        scoreboard_next = scoreboard;
        if (rf_we) begin
            scoreboard_next[rf_wa] = 1'b0;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            scoreboard_next[issue_rd] = 1'b1;
        end
        scoreboard_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scoreboard <= '0;
        end else begin
            scoreboard <= scoreboard_next;
        end
    end

`ifdef WB_BYPASS_EN
    assign byp1_valid = rf_we && (query_ra1 == rf_wa) && (query_ra1 != 5'd0);
    assign byp2_valid = rf_we && (query_ra2 == rf_wa) && (query_ra2 != 5'd0);
    assign byp1_data  = rf_wd;
    assign byp2_data  = rf_wd;
    assign busy1      = scoreboard[query_ra1] && !byp1_valid;
    assign busy2      = scoreboard[query_ra2] && !byp2_valid;
`else
    assign busy1      = scoreboard[query_ra1];
    assign busy2      = scoreboard[query_ra2];
`endif

endmodule
